ame_param_divide: RTL and testbench

- Sequential signed divider that sits directly downstream of the affine-ME numerator compute stage.
- Takes that stage's 64-bit numerator, plus a 64-bit denominator from the same solve, and produces one saturated signed affine model parameter per operation.
- Radix-2 restoring division, one quotient bit per cycle, with an init/done handshake matching the numerator stage.

---
 rtl/ame_pkg.sv | 16 +
 rtl/ame_param_divide.sv | 170 +++++++++++++++++
 tb/tb_ame_param_divide.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ame_pkg.sv
// Shared definitions for the affine motion-estimation solve: operand widths
// used by the numerator stage and the divider, and the divider state encoding.
package ame_pkg;

  localparam int AME_DATA_BITS = 64;
  localparam int AME_QUOT_BITS = 32;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_POST = 3'd3,
    DIV_DONE = 3'd4
  } ame_div_state_t;

endpackage

// File: rtl/ame_param_divide.sv
// Sequential signed divider producing one saturated affine model parameter.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, followed by sign application and clamping to QUOT_BITS.
//
// Handshake: div_init_i is sampled only in IDLE; the operands are latched on
// the accepting edge and never re-sampled. div_busy_o is high from the cycle
// after acceptance until the result cycle. div_done_o pulses for exactly one
// cycle, and div_data_o/div_zero_o/div_sat_o are valid in that cycle and held
// until the next done. There is no backpressure and no queueing.
module ame_param_divide
  import ame_pkg::*;
#(
  parameter int DATA_BITS = AME_DATA_BITS,
  parameter int QUOT_BITS = AME_QUOT_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_init_i,
  input  logic [DATA_BITS-1:0] div_num_i,
  input  logic [DATA_BITS-1:0] div_den_i,
  output logic                 div_busy_o,
  output logic                 div_done_o,
  output logic [QUOT_BITS-1:0] div_data_o,
  output logic                 div_zero_o,
  output logic                 div_sat_o,
  output ame_div_state_t       div_state_o
);

  localparam int MAG_W = DATA_BITS + 1;
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [MAG_W-1:0]     MAG_ONE  = MAG_W'(1);
  // Largest magnitudes representable for a negative / positive result.
  localparam logic [MAG_W-1:0]     NEG_LIM  = MAG_ONE << (QUOT_BITS - 1);
  localparam logic [MAG_W-1:0]     POS_LIM  = NEG_LIM - MAG_ONE;
  // The quotient occupies the low DATA_BITS bits after the last shift; the
  // top bit of the shift register holds a stale dividend bit by then.
  localparam logic [MAG_W-1:0]     QUO_MASK = ~(MAG_ONE << DATA_BITS);
  localparam logic [QUOT_BITS-1:0] Q_ONE    = QUOT_BITS'(1);
  localparam logic [QUOT_BITS-1:0] Q_MAX    = {1'b0, {(QUOT_BITS-1){1'b1}}};
  localparam logic [QUOT_BITS-1:0] Q_MIN    = {1'b1, {(QUOT_BITS-1){1'b0}}};

  ame_div_state_t state_q, state_nxt;

  logic [DATA_BITS-1:0] num_q, den_q;
  logic                 sign_q, zero_pend_q;
  logic [MAG_W-1:0]     dmag_q, rem_q, quo_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [MAG_W-1:0]     rem_shift, rem_nxt, quo_nxt, quo_mag;
  logic                 rem_ge;
  logic [QUOT_BITS-1:0] post_data;
  logic                 post_sat;

  // Magnitude in DATA_BITS+1 bits so the most negative operand is exact.
  function automatic logic [MAG_W-1:0] abs_ext(input logic [DATA_BITS-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[DATA_BITS-1], v};
    return v[DATA_BITS-1] ? (~ext + MAG_ONE) : ext;
  endfunction

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= DIV_IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic and handshake outputs decoded from the state.
  always_comb begin
    state_nxt  = state_q;
    div_busy_o = 1'b0;
    div_done_o = 1'b0;
    case (state_q)
      DIV_IDLE: if (div_init_i) state_nxt = DIV_PREP;
      DIV_PREP: begin
        div_busy_o = 1'b1;
        state_nxt  = (den_q == '0) ? DIV_POST : DIV_CALC;
      end
      DIV_CALC: begin
        div_busy_o = 1'b1;
        if (cnt_q == CNT_W'(1)) state_nxt = DIV_POST;
      end
      DIV_POST: begin
        div_busy_o = 1'b1;
        state_nxt  = DIV_DONE;
      end
      DIV_DONE: begin
        div_done_o = 1'b1;
        state_nxt  = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  assign div_state_o = state_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = (rem_q << 1) | {{DATA_BITS{1'b0}}, quo_q[DATA_BITS-1]};
    rem_ge    = (rem_shift >= dmag_q);
    rem_nxt   = rem_ge ? (rem_shift - dmag_q) : rem_shift;
    quo_nxt   = (quo_q << 1) | {{DATA_BITS{1'b0}}, rem_ge};
  end

  // Sign application (truncation toward zero) and clamping of the result.
  always_comb begin
    quo_mag   = quo_q & QUO_MASK;
    post_sat  = 1'b0;
    post_data = sign_q ? (~quo_mag[QUOT_BITS-1:0] + Q_ONE) : quo_mag[QUOT_BITS-1:0];
    if (!sign_q && (quo_mag > POS_LIM)) begin
      post_data = Q_MAX;
      post_sat  = 1'b1;
    end else if (sign_q && (quo_mag > NEG_LIM)) begin
      post_data = Q_MIN;
      post_sat  = 1'b1;
    end
  end

  // Operand capture, iteration datapath and registered result/flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      num_q       <= '0;
      den_q       <= '0;
      sign_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      dmag_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      div_data_o  <= '0;
      div_zero_o  <= 1'b0;
      div_sat_o   <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_init_i) begin
            num_q <= div_num_i;
            den_q <= div_den_i;
          end
        end
        DIV_PREP: begin
          sign_q      <= num_q[DATA_BITS-1] ^ den_q[DATA_BITS-1];
          zero_pend_q <= (den_q == '0);
          quo_q       <= abs_ext(num_q);
          dmag_q      <= abs_ext(den_q);
          rem_q       <= '0;
          cnt_q       <= CNT_W'(DATA_BITS);
        end
        DIV_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DIV_POST: begin
          if (zero_pend_q) begin
            div_data_o <= '0;
            div_zero_o <= 1'b1;
            div_sat_o  <= 1'b0;
          end else begin
            div_data_o <= post_data;
            div_zero_o <= 1'b0;
            div_sat_o  <= post_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ame_param_divide.sv
// Bench for ame_param_divide: directed sign/zero/saturation/handshake cases
// plus randomized operand pairs against a wide-arithmetic reference model.
module tb_ame_param_divide;
  import ame_pkg::*;

  localparam int DB     = 64;
  localparam int QB     = 32;
  localparam int LAT    = DB + 3;   // edges from accept (inclusive) to done cycle
  localparam int LAT_Z  = 3;
  localparam int BUDGET = 200;
  localparam int RAND_N = 500;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_init;
  logic [DB-1:0]  div_num, div_den;
  logic           busy, done, zero, sat;
  logic [QB-1:0]  data;
  ame_div_state_t st;

  int checks = 0;
  int errors = 0;
  logic [QB+1:0] exp_q[$];   // {zero, sat, data}

  // Clock and DUT.
  always #5 clk = ~clk;

  ame_param_divide dut (
    .clk_i(clk), .rst_i(rst), .div_init_i(div_init),
    .div_num_i(div_num), .div_den_i(div_den),
    .div_busy_o(busy), .div_done_o(done), .div_data_o(data),
    .div_zero_o(zero), .div_sat_o(sat), .div_state_o(st)
  );

  // Reference: exact wide signed division (truncating), then clamp.
  function automatic logic [QB+1:0] ref_div(input logic [DB-1:0] n, input logic [DB-1:0] d);
    logic signed [127:0] a, b, q;
    logic [QB-1:0] r;
    logic s;
    if (d == '0) return {1'b1, 1'b0, {QB{1'b0}}};
    a = {{64{n[DB-1]}}, n};
    b = {{64{d[DB-1]}}, d};
    q = a / b;
    s = 1'b0;
    if (q > 128'sd2147483647) begin
      r = 32'h7fff_ffff; s = 1'b1;
    end else if (q < -128'sd2147483648) begin
      r = 32'h8000_0000; s = 1'b1;
    end else begin
      r = q[QB-1:0];
    end
    return {1'b0, s, r};
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [DB-1:0] n, input logic [DB-1:0] d);
    div_num  = n;
    div_den  = d;
    div_init = 1'b1;
    exp_q.push_back(ref_div(n, d));
    tick();
    div_init = 1'b0;
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (done !== 1'b1 && lat < BUDGET) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_init = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (data !== '0)   begin errors++; $display("FAIL reset_data: got %h want 0", data); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %0b want 0", zero); end
    checks++; if (sat !== 1'b0)  begin errors++; $display("FAIL reset_sat: got %0b want 0", sat); end
    checks++; if (st !== DIV_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", st, DIV_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_signs();
    longint nums[4] = '{100, -100, 100, -100};
    longint dens[4] = '{7, 7, -7, -7};
    int     want[4] = '{14, -14, -14, 14};
    logic [QB+1:0] e;
    int lat;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sign_idle_busy[%0d]: got %0b want 0", i, busy); end
      issue(nums[i], dens[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sign_busy[%0d]: got %0b want 1", i, busy); end
      wait_done(1, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== LAT) begin errors++; $display("FAIL sign_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      checks++; if (data !== QB'(want[i])) begin errors++; $display("FAIL sign_data[%0d]: got %0d want %0d", i, $signed(data), want[i]); end
      checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL sign_model[%0d]: got %h want %h", i, {zero, sat, data}, e); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sign_done_busy[%0d]: got %0b want 0", i, busy); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sign_done_pulse[%0d]: got %0b want 0", i, done); end
      checks++; if (data !== QB'(want[i])) begin errors++; $display("FAIL sign_hold[%0d]: got %0d want %0d", i, $signed(data), want[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [QB+1:0] e;
    int lat;
    issue(64'd55, 64'd0);
    wait_done(1, lat);
    e = exp_q.pop_front();
    checks++; if (lat !== LAT_Z) begin errors++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT_Z); end
    checks++; if (data !== '0)   begin errors++; $display("FAIL zero_data: got %h want 0", data); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL zero_flag: got %0b want 1", zero); end
    checks++; if (sat !== 1'b0)  begin errors++; $display("FAIL zero_sat: got %0b want 0", sat); end
    checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL zero_model: got %h want %h", {zero, sat, data}, e); end
    tick();
  endtask

  task automatic test_saturation();
    logic [DB-1:0] nums[3] = '{64'h0000_0100_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [DB-1:0] dens[3] = '{64'd1, 64'd1, 64'hffff_ffff_ffff_ffff};
    logic [QB-1:0] want[3] = '{32'h7fff_ffff, 32'h8000_0000, 32'h7fff_ffff};
    logic [QB+1:0] e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(nums[i], dens[i]);
      wait_done(1, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== LAT) begin errors++; $display("FAIL sat_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      checks++; if (data !== want[i]) begin errors++; $display("FAIL sat_data[%0d]: got %h want %h", i, data, want[i]); end
      checks++; if (sat !== 1'b1)  begin errors++; $display("FAIL sat_flag[%0d]: got %0b want 1", i, sat); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL sat_zero[%0d]: got %0b want 0", i, zero); end
      checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL sat_model[%0d]: got %h want %h", i, {zero, sat, data}, e); end
      tick();
    end
  endtask

  task automatic test_num_zero();
    logic [QB+1:0] e;
    int lat;
    issue(64'd0, 64'hffff_ffff_ffff_fffb);
    wait_done(1, lat);
    e = exp_q.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL numzero_latency: got %0d want %0d", lat, LAT); end
    checks++; if ({zero, sat, data} !== {2'b00, {QB{1'b0}}}) begin errors++; $display("FAIL numzero_result: got %h want 0", {zero, sat, data}); end
    checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL numzero_model: got %h want %h", {zero, sat, data}, e); end
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [QB+1:0] e;
    int lat;
    issue(64'd100, 64'd7);
    lat = 1;
    while (lat < 10) begin tick(); lat++; end
    div_num  = 64'd9;
    div_den  = 64'd3;
    div_init = 1'b1;
    tick();
    lat++;
    div_init = 1'b0;
    div_num  = 64'd1;
    div_den  = 64'd1;
    wait_done(lat, lat);
    e = exp_q.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
    checks++; if (data !== 32'd14) begin errors++; $display("FAIL ignore_data: got %0d want 14", $signed(data)); end
    checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL ignore_model: got %h want %h", {zero, sat, data}, e); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [QB+1:0] e;
    int lat, total;
    div_num  = 64'd1000;
    div_den  = 64'd10;
    div_init = 1'b1;
    exp_q.push_back(ref_div(64'd1000, 64'd10));
    tick();
    div_num = -64'sd999;
    exp_q.push_back(ref_div(-64'sd999, 64'd10));
    wait_done(1, lat);
    e = exp_q.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT); end
    checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL b2b_first: got %h want %h", {zero, sat, data}, e); end
    tick();
    total = lat + 1;
    while (done !== 1'b1 && total < 2 * BUDGET) begin tick(); total++; end
    div_init = 1'b0;
    e = exp_q.pop_front();
    checks++; if (total !== 2 * LAT + 1) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", total, 2 * LAT + 1); end
    checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL b2b_second: got %h want %h", {zero, sat, data}, e); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [QB+1:0] e;
    int lat, seen;
    issue(64'd100, 64'd7);
    e = exp_q.pop_back();
    lat = 1;
    while (lat < 29) begin tick(); lat++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done, zero, sat, data} !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", {busy, done, zero, sat, data}); end
    checks++; if (st !== DIV_IDLE) begin errors++; $display("FAIL midreset_state: got %0d want %0d", st, DIV_IDLE); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen); end
    issue(64'd100, 64'd7);
    wait_done(1, lat);
    e = exp_q.pop_front();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL midreset_rerun_latency: got %0d want %0d", lat, LAT); end
    checks++; if (data !== 32'd14) begin errors++; $display("FAIL midreset_rerun_data: got %0d want 14", $signed(data)); end
    checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL midreset_rerun_model: got %h want %h", {zero, sat, data}, e); end
    tick();
  endtask

  task automatic test_random();
    logic [DB-1:0] n, d;
    logic [QB+1:0] e;
    int lat;
    for (int i = 0; i < RAND_N; i++) begin
      n = {$urandom, $urandom} >> $urandom_range(0, 63);
      d = {$urandom, $urandom} >> $urandom_range(16, 63);
      if (i % 40 == 0) n = 64'h8000_0000_0000_0000;
      if (i % 55 == 0) d = 64'd1;
      if (d == '0) d = 64'd3;
      if ($urandom_range(0, 1) == 1) n = -n;
      if ($urandom_range(0, 1) == 1) d = -d;
      issue(n, d);
      wait_done(1, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      checks++; if ({zero, sat, data} !== e) begin errors++; $display("FAIL rand_result[%0d]: n=%h d=%h got %h want %h", i, n, d, {zero, sat, data}, e); end
      tick();
    end
  endtask

  // Sequencer and final report.
  initial begin
    rst      = 1'b1;
    div_init = 1'b0;
    div_num  = '0;
    div_den  = '0;
    test_reset();
    test_signs();
    test_div_zero();
    test_saturation();
    test_num_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
